lane_oh_sequencer: RTL



---
 rtl/lane_oh_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lane_oh_sequencer.sv
// Walks the set bits of a lane mask one per handshake, as index + one-hot.
// Optional abort via `define LANE_SEQ_ABORT_EN (adds abort / aborted ports).
//
// Ports:
//   clk, reset         : clock, async active-high reset
//   start_valid/ready  : start handshake, start_ready high only in IDLE
//   start_mask         : lanes to visit, sampled on the start handshake
//   start_descending   : 0 = lowest lane first, 1 = highest lane first
//   lane_valid/ready   : per-lane handshake, one beat per visited lane
//   lane_idx, lane_oh  : current lane as index and one-hot (0 when idle)
//   lane_last          : current lane is the final set bit
//   busy, done         : in RUN; one-cycle pulse after a sequence completes
//   abort, aborted     : (optional) cancel a running sequence; pulse after it
module lane_oh_sequencer #(
   parameter int NUM_LANES = 16,
   parameter int IDX_WIDTH = $clog2(NUM_LANES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [NUM_LANES-1:0] start_mask,
   input  logic                 start_descending,
   output logic                 lane_valid,
   input  logic                 lane_ready,
   output logic [IDX_WIDTH-1:0] lane_idx,
   output logic [NUM_LANES-1:0] lane_oh,
   output logic                 lane_last,
`ifdef LANE_SEQ_ABORT_EN
   input  logic                 abort,
   output logic                 aborted,
`endif
   output logic                 busy,
   output logic                 done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [NUM_LANES-1:0] mask_q, mask_d;
   logic                 dir_q, dir_d;
   logic                 done_q, done_d;
   logic                 aborted_q, aborted_d;
   logic                 run;
   logic [IDX_WIDTH-1:0] sel_idx;

   assign run = (state_q == RUN);

   // Priority search: the last match in loop order wins, so the
   // ascending scan finds the highest bit and the descending scan the lowest.
   always_comb begin
      sel_idx = '0;
      if (dir_q) begin
         for (int i = 0; i < NUM_LANES; i++)
            if (mask_q[i]) sel_idx = IDX_WIDTH'(i);
      end else begin
         for (int i = NUM_LANES - 1; i >= 0; i--)
            if (mask_q[i]) sel_idx = IDX_WIDTH'(i);
      end
   end

   assign start_ready = !run;
   assign busy        = run;
   assign lane_valid  = run;
   assign lane_idx    = run ? sel_idx : '0;
   assign lane_oh     = run ? (NUM_LANES'(1) << sel_idx) : '0;
   // Only one bit left when clearing the lowest set bit empties the mask.
   assign lane_last   = run &&
                        ((mask_q & (mask_q - NUM_LANES'(1))) == '0);
   assign done        = done_q;

`ifdef LANE_SEQ_ABORT_EN
   assign aborted = aborted_q;
`endif

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      dir_d     = dir_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               mask_d = start_mask;
               dir_d  = start_descending;
               if (|start_mask) state_d = RUN;
               else             done_d  = 1'b1;
            end
         end
         RUN: begin
            if (lane_ready) begin
               mask_d = mask_q & ~lane_oh;
               if (lane_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
`ifdef LANE_SEQ_ABORT_EN
            // Abort overrides completion: no done, remaining lanes dropped.
            if (abort) begin
               mask_d    = '0;
               state_d   = IDLE;
               done_d    = 1'b0;
               aborted_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         dir_q     <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         dir_q     <= dir_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

endmodule
